ram_burst: RTL and testbench
============================

Name: ram_burst

Overview:
- Parametrised successor of the byte-wide on-board RAM.
- Word-wide, byte-laned synchronous RAM with a valid/ready command port and incrementing bursts of up to 2^LEN_WIDTH beats.
- Per-beat byte write strobes; read data streams back at one beat per cycle.
- Sits between the memory controller / cache refill logic and block RAM; one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 17, byte-address width (128KB).
- LANES, 4, bytes per word; power of two, at least 1.
- LEN_WIDTH, 3, burst length field width; a burst has len_in+1 beats (max 8 by default).

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- en_in  input  1  chip enable. When low, no new command is accepted; a burst already in flight completes.
- req_valid_in  input  1  command valid.
- req_ready_out  output  1  command accept. High only in IDLE with en_in=1.
- r_nw_in  input  1  command type: 1 = read, 0 = write.
- a_in  input  ADDR_WIDTH  start byte address. The low log2(LANES) bits are ignored.
- len_in  input  LEN_WIDTH  number of beats minus 1.
- wvalid_in  input  1  write beat valid.
- wready_out  output  1  write beat accept.
- d_in  input  8*LANES  write data; lane i is d_in[8i+7:8i].
- strb_in  input  LANES  byte-lane write enables for the current beat.
- rvalid_out  output  1  read beat valid.
- rlast_out  output  1  final read beat of the burst.
- d_out  output  8*LANES  read data; 0 whenever rvalid_out=0.
- wdone_out  output  1  one-cycle pulse when a write burst completes.
- busy_out  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n_in=0, asynchronous):
  - FSM goes to IDLE; beat counter and address register go to 0.
  - All outputs are 0, including req_ready_out.
  - Memory contents are not cleared.
  - A burst interrupted by reset is abandoned; beats already written stay in memory.
- Command handshake: a command is accepted on a rising edge where req_valid_in & req_ready_out. That edge is cycle T.
  - At T the block latches the word address (a_in >> log2(LANES)), len_in and r_nw_in.
- FSM states: IDLE, WRITE, READ, DONE.
  - IDLE -> WRITE on accepted write; IDLE -> READ on accepted read.
  - WRITE:
    - wready_out=1.
    - Each edge with wvalid_in=1 writes lanes whose strb_in bit is 1; lanes with strb 0 keep their old value.
    - After each such beat, the word address increments and the counter increments.
    - wvalid_in=0 stalls with no write.
    - After beat len+1 the FSM goes to DONE.
  - DONE (write): wdone_out=1 for exactly one cycle, then IDLE.
  - READ:
    - The FSM issues one word read per cycle: word address at cycle T+k for k=0..len.
    - The memory read is synchronous, plus an output register.
    - Beat k has rvalid_out=1 in cycle T+2+k, and rlast_out=1 with beat len.
    - There is no backpressure; the consumer must accept every beat.
    - After the last issue the FSM enters DONE and waits for the pipeline to drain. It returns to IDLE in the cycle after rlast_out.
    - wdone_out is not pulsed for reads.
- Ready rules:
  - req_ready_out is combinationally IDLE & en_in.
  - wready_out=1 only in WRITE.
- Wrap-around: the word address wraps from 2^(ADDR_WIDTH-log2(LANES))-1 to 0 within a burst.
- Ordering: a read accepted after a write's wdone_out returns the newly written data, with no hazard window.
- en_in falling mid-burst: the burst continues to completion; only acceptance is blocked.
- Simultaneous events:
  - wvalid_in while not in WRITE is ignored.
  - req_valid_in while busy is held off because req_ready_out=0.
- Write data / strobe: when strb_in = all zeros, the beat is consumed and counted but memory is unchanged.

Test Plan:
- Write single beat, a_in=0x10, d_in=0xDEADBEEF, strb_in=4'hF, len=0; wdone_out pulses; then read len=0 at 0x10 -> rvalid_out at T+2 with d_out=0xDEADBEEF, rlast_out=1.
- Strobe merge: word 0x20 holds 0x11223344; write 0xAABBCCDD with strb_in=4'b0101 -> readback 0x11BB33DD.
- Burst 8 write at 0x100, data 0..7, with wvalid_in dropped for 2 cycles after beat 3:
  - exactly 8 beats are written and wdone_out pulses once;
  - a burst read returns 0..7 in consecutive cycles, with rlast_out only on beat 7 and req_ready_out high the cycle after it.
- Wrap: burst-4 write at byte address 0x1FFF8 (word 0x7FFE) -> words 0x7FFE, 0x7FFF, 0x0000, 0x0001 are written; readback confirms.
- Reset mid-burst: assert rst_n_in low after beat 2 of a 5-beat write:
  - all outputs go to 0 immediately and the FSM is in IDLE after release;
  - beats 0..2 persist and beats 3..4 are unchanged.
- Enable gating: en_in=0 with req_valid_in=1 -> req_ready_out=0 and nothing is accepted; en_in dropped during a read burst -> all len+1 beats are still delivered.

Source files
------------

// File: rtl/ram_burst.sv
// ram_burst: word-wide, byte-laned synchronous RAM behind a valid/ready command port.
// Incrementing bursts of len+1 beats; read beats stream out two cycles after issue.
module ram_burst #(
  parameter int ADDR_WIDTH = 17,
  parameter int LANES      = 4,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  en_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  r_nw_in,
  input  logic [ADDR_WIDTH-1:0] a_in,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic                  wvalid_in,
  output logic                  wready_out,
  input  logic [8*LANES-1:0]    d_in,
  input  logic [LANES-1:0]      strb_in,
  output logic                  rvalid_out,
  output logic                  rlast_out,
  output logic [8*LANES-1:0]    d_out,
  output logic                  wdone_out,
  output logic                  busy_out
);

  localparam int LB = $clog2(LANES);
  localparam int WA = ADDR_WIDTH - LB;
  localparam int DW = 8 * LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_r;
  logic [WA-1:0]        addr_r;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic                 rd_op_r;
  logic                 wready_r;
  logic                 wdone_r;
  logic                 busy_r;
  logic                 issue_r;
  logic                 issue_last_r;
  logic                 rvalid_r;
  logic                 rlast_r;
  logic [DW-1:0]        mem_q_r;
  logic [DW-1:0]        d_r;
  logic [DW-1:0]        mem_r [0:(2**WA)-1];

  logic accept_s;
  logic we_s;
  logic re_s;
  logic last_beat_s;

  // Sub-word address bits select nothing: whole words are transferred.
  generate
    if (LB > 0) begin : g_lsb
      logic unused_lsb_s;
      assign unused_lsb_s = ^a_in[LB-1:0];
    end
  endgenerate

  // Handshake and memory-port strobes decoded from the current state.
  always_comb begin
    accept_s    = (state_r == IDLE) && en_in && req_valid_in;
    we_s        = (state_r == WRITE) && wvalid_in;
    re_s        = (state_r == READ);
    last_beat_s = (cnt_r == len_r);
  end

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign req_ready_out = rst_n_in && en_in && (state_r == IDLE);
  assign wready_out    = wready_r;
  assign wdone_out     = wdone_r;
  assign busy_out      = busy_r;
  assign rvalid_out    = rvalid_r;
  assign rlast_out     = rlast_r;
  assign d_out         = d_r;

  // Transaction FSM: latches the command, walks the word address, drives status outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r  <= IDLE;
      addr_r   <= '0;
      cnt_r    <= '0;
      len_r    <= '0;
      rd_op_r  <= 1'b0;
      wready_r <= 1'b0;
      wdone_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r   <= a_in[ADDR_WIDTH-1:LB];
            len_r    <= len_in;
            cnt_r    <= '0;
            rd_op_r  <= r_nw_in;
            wready_r <= !r_nw_in;
            busy_r   <= 1'b1;
            state_r  <= r_nw_in ? READ : WRITE;
          end
        end
        WRITE: begin
          if (wvalid_in) begin
            addr_r <= addr_r + WA'(1);
            cnt_r  <= cnt_r + LEN_WIDTH'(1);
            if (last_beat_s) begin
              state_r  <= DONE;
              wready_r <= 1'b0;
              wdone_r  <= 1'b1;
            end
          end
        end
        READ: begin
          addr_r <= addr_r + WA'(1);
          cnt_r  <= cnt_r + LEN_WIDTH'(1);
          if (last_beat_s) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          wdone_r <= 1'b0;
          // A read lingers here until its final beat has left the output register.
          if (!rd_op_r || rlast_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          wready_r <= 1'b0;
          wdone_r  <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  // Read return pipeline: issue flag tracks the RAM read, then the output register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      issue_r      <= 1'b0;
      issue_last_r <= 1'b0;
      rvalid_r     <= 1'b0;
      rlast_r      <= 1'b0;
      d_r          <= '0;
    end else begin
      issue_r      <= re_s;
      issue_last_r <= re_s && last_beat_s;
      rvalid_r     <= issue_r;
      rlast_r      <= issue_last_r;
      d_r          <= issue_r ? mem_q_r : '0;
    end
  end

  // Block RAM: synchronous read, per-lane masked write, contents survive reset.
  always_ff @(posedge clk_in) begin
    if (re_s) begin
      mem_q_r <= mem_r[addr_r];
    end
    for (int i = 0; i < LANES; i++) begin
      if (we_s && strb_in[i]) begin
        mem_r[addr_r][8*i +: 8] <= d_in[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_burst.sv
// Randomised self-checking bench for ram_burst against a word-array reference model.
module tb_ram_burst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        r_nw = 1'b0;
  logic [16:0] a = 17'd0;
  logic [2:0]  len = 3'd0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] d = 32'd0;
  logic [3:0]  strb = 4'd0;
  logic        rvalid;
  logic        rlast;
  logic [31:0] q;
  logic        wdone;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [0:32767];
  logic [31:0] wdata [0:7];
  logic [3:0]  wstrb [0:7];

  always #5 clk = ~clk;

  ram_burst #(.ADDR_WIDTH(17), .LANES(4), .LEN_WIDTH(3)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .en_in(en),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .r_nw_in(r_nw), .a_in(a), .len_in(len),
    .wvalid_in(wvalid), .wready_out(wready), .d_in(d), .strb_in(strb),
    .rvalid_out(rvalid), .rlast_out(rlast), .d_out(q),
    .wdone_out(wdone), .busy_out(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write burst of n beats from wdata/wstrb; optional stall beat, random stalls, reset abort.
  task automatic do_write(input logic [16:0] addr, input int n, input int stall_at,
                          input bit rnd, input int abort_at);
    int beat = 0;
    int stalled = 0;
    int guard = 0;
    bit stall;
    logic [14:0] idx;
    @(negedge clk);
    r_nw = 1'b0; a = addr; len = 3'(n - 1); req_valid = 1'b1;
    check_eq("wr_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("wr_busy", 32'(busy), 32'd1);
    while (beat < n && guard < 64) begin
      guard++;
      if (beat == abort_at) begin
        wvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_ctl", {26'd0, req_ready, wready, busy, wdone, rvalid, rlast}, 32'd0);
        check_eq("rst_dout", q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_idle", {30'd0, busy, req_ready}, 32'd1);
        return;
      end
      check_eq("wready", 32'(wready), 32'd1);
      stall = (beat == stall_at && stalled < 2) || (rnd && $urandom_range(0, 3) == 0);
      if (stall) stalled++;
      wvalid = !stall; d = wdata[beat]; strb = wstrb[beat];
      @(negedge clk);
      if (!stall) begin
        idx = addr[16:2] + 15'(beat);
        for (int i = 0; i < 4; i++)
          if (wstrb[beat][i]) ref_mem[idx][8*i +: 8] = wdata[beat][8*i +: 8];
        beat++;
      end
    end
    wvalid = 1'b0;
    check_eq("wdone_pulse", 32'(wdone), 32'd1);
    check_eq("wready_done", 32'(wready), 32'd0);
    @(negedge clk);
    check_eq("wdone_clear", 32'(wdone), 32'd0);
    check_eq("wr_idle", 32'(busy), 32'd0);
  endtask

  // Read burst with fixed latency: beat k due in cycle T+2+k.
  task automatic do_read(input logic [16:0] addr, input int n, input bit drop_en);
    logic [14:0] idx;
    @(negedge clk);
    r_nw = 1'b1; a = addr; len = 3'(n - 1); req_valid = 1'b1;
    check_eq("rd_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; r_nw = 1'b0;
    if (drop_en) en = 1'b0;
    check_eq("rd_lat0", {30'd0, rvalid, busy}, 32'd1);
    check_eq("rd_lat0_dout", q, 32'd0);
    @(negedge clk);
    check_eq("rd_lat1", 32'(rvalid), 32'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      idx = addr[16:2] + 15'(k);
      check_eq("rvalid", 32'(rvalid), 32'd1);
      check_eq("rlast", 32'(rlast), 32'(k == n - 1));
      check_eq("rdata", q, ref_mem[idx]);
      check_eq("rd_hold", {30'd0, req_ready, wdone}, 32'd0);
    end
    @(negedge clk);
    check_eq("rd_end", {30'd0, rvalid, rlast}, 32'd0);
    check_eq("rd_end_dout", q, 32'd0);
    check_eq("rd_end_busy", 32'(busy), 32'd0);
    check_eq("rd_ready_after", 32'(req_ready), 32'(!drop_en));
    en = 1'b1;
  endtask

  initial begin
    logic [16:0] ra;
    int rn;
    repeat (2) @(negedge clk);
    check_eq("por_ctl", {26'd0, req_ready, wready, busy, wdone, rvalid, rlast}, 32'd0);
    check_eq("por_dout", q, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", 32'(req_ready), 32'd1);

    wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
    do_write(17'h10, 1, -1, 1'b0, -1);
    do_read(17'h10, 1, 1'b0);

    wdata[0] = 32'h11223344; wstrb[0] = 4'hF;
    do_write(17'h20, 1, -1, 1'b0, -1);
    wdata[0] = 32'hAABBCCDD; wstrb[0] = 4'b0101;
    do_write(17'h20, 1, -1, 1'b0, -1);
    do_read(17'h20, 1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      wdata[i] = 32'(i); wstrb[i] = 4'hF;
    end
    do_write(17'h100, 8, 4, 1'b0, -1);
    do_read(17'h100, 8, 1'b0);

    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    do_write(17'h1FFF8, 4, -1, 1'b0, -1);
    do_read(17'h1FFF8, 4, 1'b0);

    for (int i = 0; i < 5; i++) wdata[i] = $urandom;
    do_write(17'h400, 5, -1, 1'b0, -1);
    for (int i = 0; i < 5; i++) wdata[i] = $urandom;
    do_write(17'h400, 5, -1, 1'b0, 3);
    do_read(17'h400, 5, 1'b0);

    @(negedge clk);
    en = 1'b0; req_valid = 1'b1; r_nw = 1'b0; a = 17'h40; len = 3'd0;
    repeat (3) begin
      @(negedge clk);
      check_eq("en_gate", {30'd0, req_ready, busy}, 32'd0);
    end
    req_valid = 1'b0; en = 1'b1;
    do_read(17'h100, 8, 1'b1);

    repeat (20) begin
      ra = 17'($urandom);
      rn = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) begin
        wdata[i] = $urandom; wstrb[i] = 4'hF;
      end
      do_write(ra, rn, -1, 1'b1, -1);
      for (int i = 0; i < 8; i++) begin
        wdata[i] = $urandom; wstrb[i] = 4'($urandom);
      end
      do_write(ra, rn, -1, 1'b1, -1);
      do_read(ra, rn, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
